// File: rtl/matrix_skewer.sv
// matrix_skewer: feed side of a 4x4 systolic array.
// Latches a full 4x4 matrix on a start handshake. It then emits the matrix on four row lanes
// in diagonal-wavefront order, so that lane i runs i cycles behind lane 0.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     load m_in and begin feeding (accepted only while ready=1)
//   m_in      matrix, element (r,c) at bits [(4*r+c)*W +: W]
//   stall     freeze step counter and lane outputs while feeding
//   ready     high in idle, can accept start
//   q1..q4    registered lane outputs, qi feeds array row i-1
//   lane_vld  bit i-1 set when qi carries a real element
//   step      wavefront index k (0..6) while feeding, 0 otherwise
//   done      single-cycle pulse once the whole wavefront has entered
module matrix_skewer #(
  parameter int unsigned W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [16*W-1:0] m_in,
  input  logic            stall,
  output logic            ready,
  output logic [W-1:0]    q1,
  output logic [W-1:0]    q2,
  output logic [W-1:0]    q3,
  output logic [W-1:0]    q4,
  output logic [3:0]      lane_vld,
  output logic [2:0]      step,
  output logic            done
);

  typedef enum logic [1:0] {StIdle, StFeed, StFin} state_e;

  state_e         state_q, state_d;
  // Number of wavefront steps already presented in this feed (0..7).
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     step_q, step_d;
  logic [3:0]     vld_q, vld_d;
  logic [W-1:0]   lane_q [4];
  logic [W-1:0]   lane_d [4];
  logic [W-1:0]   mat_q [16];
  logic [W-1:0]   mat_d [16];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    vld_d   = vld_q;
    lane_d  = lane_q;
    mat_d   = mat_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int r = 0; r < 16; r++) begin
            mat_d[r] = m_in[r*W +: W];
          end
          cnt_d   = '0;
          step_d  = '0;
          state_d = StFeed;
        end
      end

      StFeed: begin
        if (!stall) begin
          if (cnt_q == 3'd7) begin
            // All seven wavefront steps have been shown; clear lanes and signal done.
            state_d = StFin;
            step_d  = '0;
            vld_d   = '0;
            for (int i = 0; i < 4; i++) begin
              lane_d[i] = '0;
            end
          end else begin
            step_d = cnt_q;
            cnt_d  = cnt_q + 3'd1;
            // Lane i shows column j = k - i of row i; the element index 4*i + j is 3*i + k.
            for (int i = 0; i < 4; i++) begin
              if (int'(cnt_q) >= i && int'(cnt_q) <= i + 3) begin
                lane_d[i] = mat_q[4'(3*i) + {1'b0, cnt_q}];
                vld_d[i]  = 1'b1;
              end else begin
                lane_d[i] = '0;
                vld_d[i]  = 1'b0;
              end
            end
          end
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      step_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      for (int r = 0; r < 16; r++) begin
        mat_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      vld_q   <= vld_d;
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= lane_d[i];
      end
      for (int r = 0; r < 16; r++) begin
        mat_q[r] <= mat_d[r];
      end
    end
  end

  assign ready    = (state_q == StIdle);
  assign done     = (state_q == StFin);
  assign step     = step_q;
  assign lane_vld = vld_q;
  assign q1       = lane_q[0];
  assign q2       = lane_q[1];
  assign q3       = lane_q[2];
  assign q4       = lane_q[3];

endmodule

// File: tb/tb_matrix_skewer.sv
// Scoreboard bench for matrix_skewer. The stimulus side predicts each clock edge from a
// wavefront model and queues the expected outputs. The monitor pops those expectations
// and compares them whenever the DUT presents lanes or done.
module tb_matrix_skewer;
  localparam int W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            stall = 1'b0;
  logic [16*W-1:0] m_in = '0;
  logic            ready;
  logic [W-1:0]    q1, q2, q3, q4;
  logic [3:0]      lane_vld;
  logic [2:0]      step;
  logic            done;

  matrix_skewer #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .m_in     (m_in),
    .stall    (stall),
    .ready    (ready),
    .q1       (q1),
    .q2       (q2),
    .q3       (q3),
    .q4       (q4),
    .lane_vld (lane_vld),
    .step     (step),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*W-1:0] q;     // lane i at [i*W +: W]
    logic [3:0]     vld;
    logic [2:0]     step;
    logic           done;
  } rec_t;

  int   n_chk = 0;
  int   n_pass = 0;
  rec_t exp_q[$];
  bit   rdy_q[$];
  bit   mon_on = 1'b0;

  // Reference model state: busy while a feed is in progress.
  // adv counts the non-stalled edges since accept.
  bit           busy = 1'b0;
  int           adv = 0;
  logic [W-1:0] mm [16];

  logic [16*W-1:0] base_m;
  logic [16*W-1:0] ff_m;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Wavefront k: lane i carries M[i][k-i] when that column exists.
  function automatic rec_t show(input int k);
    rec_t r;
    int   j;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      j = k - i;
      if (j >= 0 && j <= 3) begin
        r.q[i*W +: W] = mm[4*i + j];
        r.vld[i]      = 1'b1;
      end
    end
    r.step = 3'(k);
    return r;
  endfunction

  function automatic logic [16*W-1:0] rand_mat();
    logic [16*W-1:0] m;
    for (int r = 0; r < 16; r++) m[r*W +: W] = $urandom;
    return m;
  endfunction

  task automatic model_edge(input bit st, input logic [16*W-1:0] m, input bit stl);
    rec_t d;
    if (!busy) begin
      if (st) begin
        busy = 1'b1;
        adv  = 0;
        for (int r = 0; r < 16; r++) mm[r] = m[r*W +: W];
      end
    end else if (adv < 8) begin
      if (!stl) adv++;
      if (adv >= 1 && adv <= 7) begin
        exp_q.push_back(show(adv - 1));
      end else if (adv == 8) begin
        d      = '0;
        d.done = 1'b1;
        exp_q.push_back(d);
      end
    end else begin
      busy = 1'b0;
    end
    rdy_q.push_back(!busy);
  endtask

  // Drive the inputs for the next rising edge, predict that edge, then move past it.
  task automatic cycle(input bit st, input logic [16*W-1:0] m, input bit stl);
    start  = st;
    m_in   = m;
    stall  = stl;
    model_edge(st, m, stl);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_lanes"}, {q4, q3, q2, q1}, '0);
    chk({tag, "_vld"}, lane_vld, 4'b0000);
    chk({tag, "_step"}, step, 3'd0);
    chk({tag, "_ready"}, ready, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
  endtask

  // Assert reset between a monitor sample and the next edge. The reset takes effect
  // without any clock edge.
  task automatic mid_reset();
    #6;
    rst_n = 1'b0;
    busy  = 1'b0;
    #1;
    check_reset_vals("async_rst");
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    rec_t e;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (rdy_q.size() == 0) chk("ready_expectation_missing", ready, 1'bx);
        else chk("ready", ready, rdy_q.pop_front());
        if (lane_vld != 4'b0000 || done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", {lane_vld, done}, '0);
          end else begin
            e = exp_q.pop_front();
            chk("lanes", {q4, q3, q2, q1}, e.q);
            chk("lane_vld", lane_vld, e.vld);
            chk("step", step, e.step);
            chk("done", done, e.done);
          end
        end else begin
          chk("idle_lanes", {q4, q3, q2, q1}, '0);
          chk("idle_step", step, 3'd0);
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        base_m[(4*r + c)*W +: W] = 32'(16*(r + 1) + (c + 1));
        ff_m[(4*r + c)*W +: W]   = 32'hFF;
      end
    end

    #1;
    check_reset_vals("reset");
    #11;
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Basic feed
    cycle(1'b1, base_m, 1'b0);
    repeat (10) cycle(1'b0, base_m, 1'b0);

    // Stall held over k=2 for three edges
    cycle(1'b1, base_m, 1'b0);
    for (int n = 1; n <= 14; n++) cycle(1'b0, base_m, (n >= 4 && n <= 6));

    // Start while busy with different data is ignored
    cycle(1'b1, base_m, 1'b0);
    for (int n = 1; n <= 12; n++) cycle(n == 6, (n == 6) ? ff_m : base_m, 1'b0);

    // m_in changes right after accept
    cycle(1'b1, base_m, 1'b0);
    repeat (11) cycle(1'b0, '0, 1'b0);

    // Stall asserted at the accept edge still accepts
    cycle(1'b1, base_m, 1'b1);
    repeat (11) cycle(1'b0, base_m, 1'b0);

    // Asynchronous reset with k=3 on the lanes, then a fresh feed
    cycle(1'b1, base_m, 1'b0);
    repeat (4) cycle(1'b0, base_m, 1'b0);
    mid_reset();
    cycle(1'b1, base_m, 1'b0);
    repeat (10) cycle(1'b0, base_m, 1'b0);

    // Start held high: back-to-back feeds
    repeat (25) cycle(1'b1, rand_mat(), 1'b0);

    // Random traffic
    repeat (400) cycle($urandom_range(0, 3) == 0, rand_mat(), $urandom_range(0, 3) == 0);

    // Drain
    repeat (12) cycle(1'b0, '0, 1'b0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("ready_queue_drained", rdy_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
